// File: rtl/step_sequencer_161.sv
// step_sequencer_161: micro-step counter with extension flag and terminal count.
// Define SEQ_PARALLEL_LOAD_EN to add load_value, loaded on step clear.
module step_sequencer_161 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_resetn,
  input  logic             step_extn,
  input  logic             ctrlen,
`ifdef SEQ_PARALLEL_LOAD_EN
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] step,
  output logic             ext,
  output logic             tc
);
  logic             cnt_en;
  logic [WIDTH-1:0] clear_value;
`ifdef SEQ_PARALLEL_LOAD_EN
  assign clear_value = load_value;
`else
  assign clear_value = '0;
`endif
  assign cnt_en = step_extn & ~ctrlen;
  assign tc     = ~ctrlen & (&step);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step <= '0;
      ext  <= 1'b0;
    end else begin
      step <= !step_resetn ? clear_value : cnt_en ? step + 1'b1 : step;
      ext  <= step_resetn & (~step_extn | ext);
    end
endmodule

// File: tb/tb_step_sequencer_161.sv
// tb_step_sequencer_161: directed and random checks against a behavioural model.
module tb_step_sequencer_161;
  localparam int W = 4;
  localparam int M = 1 << W;
  logic clk = 0, rst = 0, step_resetn = 1, step_extn = 1, ctrlen = 0;
  logic [W-1:0] step;
  logic ext, tc;
`ifdef SEQ_PARALLEL_LOAD_EN
  logic [W-1:0] load_value = '0;
`endif
  int errors = 0, checks = 0;
  int ref_step = 0, ref_ext = 0;

  step_sequencer_161 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .step_resetn(step_resetn), .step_extn(step_extn), .ctrlen(ctrlen),
`ifdef SEQ_PARALLEL_LOAD_EN
    .load_value(load_value),
`endif
    .step(step), .ext(ext), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".step"}, 32'(step), 32'(ref_step));
    chk({tag, ".ext"}, 32'(ext), 32'(ref_ext));
    chk({tag, ".tc"}, 32'(tc), 32'((ref_step == M - 1) && !ctrlen));
  endtask

  task automatic cycle(input string tag, input logic sr, input logic ex, input logic ce);
    int load;
    step_resetn = sr;
    step_extn = ex;
    ctrlen = ce;
    load = 0;
`ifdef SEQ_PARALLEL_LOAD_EN
    load = int'(load_value);
`endif
    @(posedge clk);
    if (!rst) begin
      if (!sr) ref_step = load;
      else if (ex && !ce) ref_step = (ref_step + 1) % M;
      ref_ext = !sr ? 0 : !ex ? 1 : ref_ext;
    end
    #1 chk_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    ref_step = 0;
    ref_ext = 0;
    #1 chk_all("reset");
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 17; i++) cycle("count", 1, 1, 0);
    chk("wrap_end", 32'(step), 32'd1);
    for (int i = 0; i < 5; i++) cycle("to6", 1, 1, 0);
    chk("at6", 32'(step), 32'd6);
    cycle("clear", 0, 1, 0);
    cycle("resume", 1, 1, 0);
    chk("resume1", 32'(step), 32'd1);
    cycle("to2", 1, 1, 0);
    cycle("to3", 1, 1, 0);
    cycle("extend", 1, 0, 0);
    chk("ext_hold3", 32'(step), 32'd3);
    chk("ext_set", 32'(ext), 32'd1);
    cycle("ext_resume", 1, 1, 0);
    chk("ext_at4", 32'(step), 32'd4);
    cycle("ext_clear", 0, 1, 0);
    cycle("clr_and_ext", 0, 0, 0);
    chk("clear_wins", 32'(ext), 32'd0);
    for (int i = 0; i < 15; i++) cycle("to15", 1, 1, 0);
    chk("tc15", 32'(tc), 32'd1);
    ctrlen = 1;
    #1 chk("tc_gate", 32'(tc), 32'd0);
    for (int i = 0; i < 3; i++) cycle("frozen", 1, 1, 1);
    chk("frozen15", 32'(step), 32'd15);
    cycle("unfreeze", 1, 1, 0);
    chk("wrap0", 32'(step), 32'd0);
    for (int i = 0; i < 9; i++) cycle("to9", 1, 1, 0);
    cycle("ext9", 1, 0, 0);
    chk("pre_rst_ext", 32'(ext), 32'd1);
    #2 rst = 1;
    ref_step = 0;
    ref_ext = 0;
    #1 chk_all("async_rst");
    for (int i = 0; i < 2; i++) cycle("rst_hold", 1, 0, 0);
    @(negedge clk);
    rst = 0;
    cycle("post_rst", 1, 1, 0);
`ifdef SEQ_PARALLEL_LOAD_EN
    load_value = 4'hA;
    cycle("pload", 0, 1, 0);
    chk("pload10", 32'(step), 32'd10);
    cycle("pload_inc", 1, 1, 0);
    chk("pload11", 32'(step), 32'd11);
`endif
    for (int i = 0; i < 300; i++) begin
`ifdef SEQ_PARALLEL_LOAD_EN
      load_value = W'($urandom);
`endif
      if ($urandom_range(0, 49) == 0) do_reset();
      cycle("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
